// File: rtl/brv32p_pkg.sv
// Shared types for the RV32M multiply/divide unit: op encoding (funct3),
// FSM states and a small conditional-negate helper.
package brv32p_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } muldiv_state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> muldiv handshake: op request, flush, busy stall and result.
interface muldiv_unit_if;
    import brv32p_pkg::*;

    logic             start;
    muldiv_op_e       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;

    modport master (output start, op, a, b, flush, input busy, done, result);
    modport slave  (input start, op, a, b, flush, output busy, done, result);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiplier (MUL_BITS_PER_CYCLE bits/cycle) and
// restoring divider (1 bit/cycle) sharing one 64-bit accumulator and counter.
module muldiv_unit
    import brv32p_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    localparam int         MBPC      = MUL_BITS_PER_CYCLE;
    localparam logic [5:0] MUL_ITERS = 6'(XLEN / MBPC);
    localparam logic [5:0] DIV_ITERS = 6'(XLEN);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN+MBPC-1:0] mul_sum;
    logic [2*XLEN-1:0]    mul_next, div_next, acc_step, product;
    logic [XLEN:0]        div_trial;
    logic                 sa_in, sb_in, is_special;
    logic [XLEN-1:0]      special_res, calc_res;

    // One iteration of each datapath; acc holds {partial product | multiplier}
    // for mul and {remainder | quotient-in-progress} for div.
    always_comb begin
        mul_sum   = {{MBPC{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                  + (XLEN+MBPC)'(opnd_q) * (XLEN+MBPC)'(acc_q[MBPC-1:0]);
        mul_next  = {mul_sum, acc_q[XLEN-1:MBPC]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_step  = op_q[2] ? div_next : mul_next;
        product   = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;

        if (!op_q[2])
            calc_res = (op_q == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        else if (op_q[1])
            calc_res = neg_if(acc_step[2*XLEN-1:XLEN], neg_a_q);
        else
            calc_res = neg_if(acc_step[XLEN-1:0], neg_a_q ^ neg_b_q);
    end

    always_comb begin
        sa_in = bus.a[XLEN-1] & (bus.op == MD_MULH || bus.op == MD_MULHSU ||
                                 bus.op == MD_DIV  || bus.op == MD_REM);
        sb_in = bus.b[XLEN-1] & (bus.op == MD_MULH || bus.op == MD_DIV || bus.op == MD_REM);

        is_special  = bus.op[2] && (bus.b == '0 ||
                      (!bus.op[0] && bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF));
        if (bus.b == '0)
            special_res = bus.op[1] ? bus.a : 32'hFFFF_FFFF;
        else
            special_res = bus.op[1] ? 32'h0 : 32'h8000_0000;
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                bus.busy = bus.start & ~bus.flush;
                if (bus.start && !bus.flush) begin
                    op_d    = bus.op;
                    neg_a_d = sa_in;
                    neg_b_d = sb_in;
                    opnd_d  = neg_if(bus.b, sb_in);
                    acc_d   = {{XLEN{1'b0}}, neg_if(bus.a, sa_in)};
                    cnt_d   = bus.op[2] ? DIV_ITERS : MUL_ITERS;
                    if (is_special) begin
                        state_d  = MD_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                bus.busy = 1'b1;
                acc_d    = acc_step;
                cnt_d    = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d  = MD_DONE;
                    result_d = calc_res;
                end
            end
            MD_DONE: begin
                bus.done = 1'b1;
                state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        // A flushed op never completes and leaves the previous result visible.
        if (bus.flush) begin
            state_d  = MD_IDLE;
            bus.done = 1'b0;
            result_d = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: one 1-bit/cycle and one
// 4-bit/cycle instance, latency/busy/done/result checked per op.
module tb_muldiv_unit;
    import brv32p_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if bus ();
    muldiv_unit_if bus4 ();

    muldiv_unit #(.MUL_BITS_PER_CYCLE(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    muldiv_unit #(.MUL_BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start  = 1'b0; bus.flush  = 1'b0; bus.op  = MD_MUL; bus.a  = '0; bus.b  = '0;
        bus4.start = 1'b0; bus4.flush = 1'b0; bus4.op = MD_MUL; bus4.a = '0; bus4.b = '0;
    endtask

    // Start an op at cycle 0, then watch busy/done every cycle up to lat+1.
    task automatic do_op(input string tag, input bit use4, input muldiv_op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int   done_cyc = -1;
        int   ndone    = 0;
        int   busy_bad = 0;
        logic bsy, dn;
        logic [31:0] res;
        @(posedge clk); #1;
        if (use4) begin bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b; end
        else      begin bus.start  = 1'b1; bus.op  = op; bus.a  = a; bus.b  = b; end
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            bsy = use4 ? bus4.busy : bus.busy;
            dn  = use4 ? bus4.done : bus.done;
            if (bsy !== (c < lat)) busy_bad++;
            if (dn === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                bus.start = 1'b0;  bus.a  = $urandom; bus.b  = $urandom;
                bus4.start = 1'b0; bus4.a = $urandom; bus4.b = $urandom;
            end
        end
        res = use4 ? bus4.result : bus.result;
        check({tag, " busy pattern errors"}, busy_bad, 0);
        check({tag, " done cycle"}, done_cyc, lat);
        check({tag, " done count"}, ndone, 1);
        check({tag, " result"}, res, exp);
    endtask

    initial begin
        int ndone, first_done, second_done;

        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset result", bus.result, 0);
        check("reset result x4", bus4.result, 0);

        // Multiply, 1 bit per cycle
        do_op("MUL 7*-3",        0, MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULH min*min",    0, MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        do_op("MULHSU -1*max",   0, MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("MULHU max*max",   0, MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULHU 7*fffffffd",0, MD_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33);
        do_op("MULH 7*-3",       0, MD_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);

        // Multiply, 4 bits per cycle
        do_op("x4 MUL 7*-3",     1, MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 9);
        do_op("x4 MULH min*min", 1, MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 9);
        do_op("x4 MULHU max*max",1, MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);

        // Divide
        do_op("DIVU 100/7",      0, MD_DIVU,   32'd100,        32'd7,         32'd14,        33);
        do_op("REMU 100/7",      0, MD_REMU,   32'd100,        32'd7,         32'd2,         33);
        do_op("DIV -7/2",        0, MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op("REM -7/2",        0, MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op("DIV min/3",       0, MD_DIV,    32'h8000_0000,  32'd3,         32'hD555_5556, 33);
        do_op("REM min/3",       0, MD_REM,    32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 33);

        // Special cases complete in one cycle
        do_op("DIV 5/0",         0, MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        do_op("REM 5/0",         0, MD_REM,    32'd5,          32'd0,         32'd5,         1);
        do_op("DIVU 5/0",        0, MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        do_op("DIV ovf",         0, MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",         0, MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Flush mid-divide, then a new MUL the cycle after
        do_op("DIVU 100/7 again",0, MD_DIVU,   32'd100,        32'd7,         32'd14,        33);
        ndone = 0; first_done = -1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk);
            if (c == 10) check("flush busy during flush cycle", bus.busy, 1);
            if (c == 43) check("flush result held", bus.result, 32'd14);
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            @(posedge clk); #1;
            case (c)
                0:  bus.start = 1'b0;
                9:  bus.flush = 1'b1;
                10: begin
                    bus.flush = 1'b0;
                    #1 check("flush busy after flush", bus.busy, 0);
                    bus.start = 1'b1; bus.op = MD_MUL; bus.a = 32'd3; bus.b = 32'd4;
                end
                11: bus.start = 1'b0;
                default: ;
            endcase
        end
        check("flush done count", ndone, 1);
        check("flush MUL done cycle", first_done, 44);
        check("flush MUL result", bus.result, 32'd12);

        // Reset in the middle of a divide
        ndone = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 6) begin
                check("rst busy", bus.busy, 0);
                check("rst done", bus.done, 0);
                check("rst result", bus.result, 0);
            end
            if (bus.done === 1'b1) ndone++;
            @(posedge clk); #1;
            if (c == 0) bus.start = 1'b0;
            if (c == 4) rst_n = 1'b0;
            if (c == 5) rst_n = 1'b1;
        end
        check("rst no done", ndone, 0);

        // Back-to-back MULs; start held in the DONE cycle must be ignored
        ndone = 0; first_done = -1; second_done = -1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MD_MUL; bus.a = 32'd5; bus.b = 32'd6;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            if (c == 33) begin
                check("b2b busy in DONE", bus.busy, 0);
                check("b2b first result", bus.result, 32'd30);
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            @(posedge clk); #1;
            if (c == 0)  bus.start = 1'b0;
            if (c == 32) begin bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; end
            if (c == 34) bus.start = 1'b0;
        end
        check("b2b done count", ndone, 2);
        check("b2b first done cycle", first_done, 33);
        check("b2b second done cycle", second_done, 67);
        check("b2b second result", bus.result, 32'd81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
